// File: rtl/sample_capture.sv
// Triggered capture of a signed sample stream into RAM, replayed over a valid/ready port.
// Optional decimation of the captured stream is built in when CAPTURE_DECIM_EN is defined.
module sample_capture #(
  parameter int NB_DATA  = 16,
  parameter int DEPTH    = 1024,
  parameter int NB_DECIM = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NB_DATA-1:0]         i_data,
  input  logic                       i_valid,
  input  logic                       i_arm,
  input  logic                       i_trig,
  input  logic [NB_DECIM-1:0]        i_decim,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [NB_DATA-1:0]         o_rd_data,
  output logic                       o_rd_valid,
  input  logic                       i_rd_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_READOUT} state_t;

  state_t              r_state, w_state_nxt;
  logic [NB_DATA-1:0]  r_mem [DEPTH];
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_rd_ptr;
  logic [NB_DATA-1:0]  r_rd_data;
  logic                r_rd_valid;
  logic                r_done;

  logic w_wr_en, w_fetch, w_clr_count, w_trig_acc, w_done_nxt, w_keep, w_hs;

  assign w_trig_acc = (r_state == ST_ARMED) && i_trig && i_valid;
  assign w_hs       = r_rd_valid && i_rd_ready;

`ifdef CAPTURE_DECIM_EN
  logic [NB_DECIM-1:0] r_decim, r_decim_cnt;

  // Trigger sample is always stored; afterwards only the sample where the counter wraps.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_decim     <= '0;
      r_decim_cnt <= '0;
    end else if (w_trig_acc) begin
      r_decim     <= i_decim;
      r_decim_cnt <= '0;
    end else if (r_state == ST_CAPTURE && i_valid) begin
      r_decim_cnt <= (r_decim_cnt == r_decim) ? '0 : r_decim_cnt + NB_DECIM'(1);
    end
  end

  assign w_keep = (r_decim_cnt == r_decim);
`else
  logic w_unused;
  assign w_unused = ^{i_decim, w_trig_acc};
  assign w_keep   = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_fetch     = 1'b0;
    w_clr_count = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_arm) begin
          w_state_nxt = ST_ARMED;
          w_clr_count = 1'b1;
        end
      end
      ST_ARMED: begin
        if (i_trig && i_valid) begin
          w_state_nxt = ST_CAPTURE;
          w_wr_en     = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (i_valid && w_keep) begin
          w_wr_en = 1'b1;
          if (r_count == CW'(DEPTH - 1)) w_state_nxt = ST_READOUT;
        end
      end
      ST_READOUT: begin
        // Output register doubles as the skid stage: refill when empty or being drained.
        w_fetch = (r_rd_ptr != CW'(DEPTH)) && (!r_rd_valid || i_rd_ready);
        if (w_hs && r_rd_ptr == CW'(DEPTH)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_count[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_clr_count)  r_count <= '0;
      else if (w_wr_en) r_count <= r_count + CW'(1);
      if (r_state != ST_READOUT) r_rd_ptr <= '0;
      else if (w_fetch)          r_rd_ptr <= r_rd_ptr + CW'(1);
      if (w_fetch) begin
        r_rd_data  <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_valid <= 1'b1;
      end else if (w_hs) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;
  assign o_count    = r_count;
  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule
